// File: rtl/subtract_sequencer_pkg.sv
// Shared types and constants for the nibble-serial subtract sequencer.
// Holds the FSM state enum, the datapath slice width and the index-width helper.
package subtract_sequencer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble operand still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/subtract_sequencer_subtractor.sv
// 4-bit ripple subtractor: diff = a - b - bin, bout = borrow out of the top bit.
// Purely combinational, zero latency, no flow control.
// Reused serially by the subtract sequencer, one nibble per clock.
module subtractor
  import subtract_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                bout
);

  logic [NIBBLE_W:0] br;

  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = bin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  end

  assign bout = br[NIBBLE_W];

endmodule

// File: rtl/subtract_sequencer.sv
// Multi-precision A - B - borrow_in, one nibble per clock LSB first; optional zero flag via SUBTRACT_SEQUENCER_ZERO_FLAG_EN.
// Latency: accept edge + WORDS RUN cycles, one op per WORDS+2 cycles with out_ready high.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module subtract_sequencer
  import subtract_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NIBBLE_W*WORDS-1:0] operand_a,
  input  logic [NIBBLE_W*WORDS-1:0] operand_b,
  input  logic                  borrow_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NIBBLE_W*WORDS-1:0] difference,
  output logic                  borrow,
`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
  output logic                  zero,
`endif
  output logic                  overflow
);

  localparam int W     = NIBBLE_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state, state_nxt;
  logic [W-1:0]       a_q, b_q, res_q, res_nxt;
  logic               brw_q;
  logic [IDX_W-1:0]   idx;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_diff;
  logic               nib_bout;
  logic               last_nib;

  assign nib_a    = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b    = b_q[idx*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (idx == LAST_IDX);

  subtractor u_sub (
    .a    (nib_a),
    .b    (nib_b),
    .bin  (brw_q),
    .diff (nib_diff),
    .bout (nib_bout)
  );

  always_comb begin
    res_nxt = res_q;
    res_nxt[idx*NIBBLE_W +: NIBBLE_W] = nib_diff;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Working result lives in res_q so the visible outputs only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      brw_q      <= 1'b0;
      idx        <= '0;
      difference <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= operand_a;
          b_q   <= operand_b;
          brw_q <= borrow_in;
          res_q <= '0;
          idx   <= '0;
        end
        RUN: begin
          res_q <= res_nxt;
          brw_q <= nib_bout;
          if (last_nib) begin
            difference <= res_nxt;
            borrow     <= nib_bout;
            overflow   <= (a_q[W-1] ^ b_q[W-1]) & (nib_diff[NIBBLE_W-1] ^ a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
  logic zero_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_acc <= 1'b0;
      zero     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      zero_acc <= 1'b1;
    end else if (state == RUN) begin
      zero_acc <= zero_acc & (nib_diff == '0);
      if (last_nib) zero <= zero_acc & (nib_diff == '0);
    end
  end
`endif

endmodule

// File: tb/tb_subtract_sequencer.sv
// Directed-vector bench for subtract_sequencer (WORDS=4) with hand-computed results.
module tb_subtract_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] difference;
  logic        borrow;
  logic        overflow;
`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
  logic        zero;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  subtract_sequencer #(.WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow     (borrow),
`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
    .zero       (zero),
`endif
    .overflow   (overflow)
  );

  // Launches one op from IDLE and waits (bounded) for out_valid; leaves the bench in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int cyc, output logic ok);
    operand_a = a;
    operand_b = b;
    borrow_in = bin;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = out_valid;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (difference !== 16'h0000) begin miscompares++; $display("FAIL reset_difference got %h want 0000", difference); end
    vectors++;
    if (borrow !== 1'b0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got borrow=%b overflow=%b want 0 0", borrow, overflow);
    end
`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
    vectors++;
    if (zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b want 0", zero); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; logic ok;
    run_op(16'h1234, 16'h0234, 1'b0, cyc, ok);
    vectors++;
    if (!ok || cyc != 5) begin miscompares++; $display("FAIL basic_latency got cyc=%0d valid=%b want 5 1", cyc, ok); end
    vectors++;
    if (difference !== 16'h1000) begin miscompares++; $display("FAIL basic_diff got %h want 1000", difference); end
    vectors++;
    if (borrow !== 1'b0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL basic_flags got borrow=%b overflow=%b want 0 0", borrow, overflow);
    end
    handoff();
  endtask

  task automatic test_wrap();
    int cyc; logic ok;
    run_op(16'h0000, 16'h0001, 1'b0, cyc, ok);
    vectors++;
    if (!ok || difference !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_diff got %h valid=%b want ffff", difference, ok); end
    vectors++;
    if (borrow !== 1'b1 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL wrap_flags got borrow=%b overflow=%b want 1 0", borrow, overflow);
    end
    handoff();
    run_op(16'h0005, 16'h0005, 1'b1, cyc, ok);
    vectors++;
    if (!ok || difference !== 16'hFFFF) begin miscompares++; $display("FAIL bin_diff got %h valid=%b want ffff", difference, ok); end
    vectors++;
    if (borrow !== 1'b1) begin miscompares++; $display("FAIL bin_borrow got %b want 1", borrow); end
    handoff();
  endtask

  task automatic test_overflow();
    int cyc; logic ok;
    run_op(16'h8000, 16'h0001, 1'b0, cyc, ok);
    vectors++;
    if (!ok || difference !== 16'h7FFF) begin miscompares++; $display("FAIL ovf_diff got %h valid=%b want 7fff", difference, ok); end
    vectors++;
    if (borrow !== 1'b0 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_flags got borrow=%b overflow=%b want 0 1", borrow, overflow);
    end
    handoff();
  endtask

  task automatic test_backpressure();
    int cyc; logic ok;
    out_ready = 1'b0;
    run_op(16'h00FF, 16'h0010, 1'b0, cyc, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_valid got %b want 1", ok); end
    for (int i = 0; i < 10; i++) begin
      in_valid  = i[0];
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || difference !== 16'h00EF || borrow !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got valid=%b in_ready=%b diff=%h borrow=%b want 1 0 00ef 0",
                 i, out_valid, in_ready, difference, borrow);
      end
    end
    in_valid = 1'b0;
    handoff();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_handoff got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_single got valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic ok; logic seen;
    operand_a = 16'h4444;
    operand_b = 16'h1111;
    borrow_in = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_idle got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_no_result got valid_seen=%b want 0", seen); end
    run_op(16'h0003, 16'h0001, 1'b0, cyc, ok);
    vectors++;
    if (!ok || difference !== 16'h0002 || borrow !== 1'b0) begin
      miscompares++; $display("FAIL midrst_next got %h borrow=%b valid=%b want 0002 0 1", difference, borrow, ok);
    end
    handoff();
  endtask

`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
  task automatic test_zero();
    int cyc; logic ok;
    run_op(16'hBEEF, 16'hBEEF, 1'b0, cyc, ok);
    vectors++;
    if (!ok || zero !== 1'b1 || difference !== 16'h0000) begin
      miscompares++; $display("FAIL zero_equal got zero=%b diff=%h want 1 0000", zero, difference);
    end
    handoff();
    run_op(16'hBEEF, 16'hBEEE, 1'b0, cyc, ok);
    vectors++;
    if (!ok || zero !== 1'b0 || difference !== 16'h0001) begin
      miscompares++; $display("FAIL zero_nonzero got zero=%b diff=%h want 0 0001", zero, difference);
    end
    handoff();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    operand_a = '0;
    operand_b = '0;
    borrow_in = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_backpressure();
    test_reset_mid();
`ifdef SUBTRACT_SEQUENCER_ZERO_FLAG_EN
    test_zero();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
